// File: rtl/dpr_fifo_ctrl_pkg.sv
// Purpose: shared constants and types for the dual-port-RAM FIFO controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpr_fifo_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int RAM_DEPTH_DEF  = 1 << ADDR_WIDTH_DEF;
    // The two-entry output buffer adds to what the RAM alone can hold.
    localparam int OBUF_DEPTH     = 2;
    localparam int CAPACITY_DEF   = RAM_DEPTH_DEF + OBUF_DEPTH;

    // Occupancy of the output buffer: 0, 1 or 2.
    typedef logic [1:0] obuf_cnt_t;

endpackage

// File: rtl/dpr_fifo_ctrl_if.sv
// Purpose: push/pop handshake bundle between the FIFO and its neighbours.
// Latency: n/a (wires only).
// Backpressure: in_ready throttles the producer, out_ready throttles the FIFO.
// Ports: in_valid/in_data/in_ready (push side), out_valid/out_data/out_ready (pop side).
interface dpr_fifo_ctrl_if #(
    parameter int DATA_WIDTH = dpr_fifo_ctrl_pkg::DATA_WIDTH_DEF
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    // Environment side: produces pushes and consumes pops.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // FIFO side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dpr_fifo_obuf.sv
// Purpose: two-entry output buffer holding words returned from the RAM read port.
// Latency: a loaded word is visible at head the cycle after the load edge.
// Backpressure: none internally; the controller never loads while two are held without a pop.
// Ports: clk, rst_n, load/load_data (write), pop (remove head), head, count.
module dpr_fifo_obuf #(
    parameter int DATA_WIDTH = dpr_fifo_ctrl_pkg::DATA_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic [DATA_WIDTH-1:0]        load_data,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        head,
    output dpr_fifo_ctrl_pkg::obuf_cnt_t count
);
    import dpr_fifo_ctrl_pkg::*;

    logic [DATA_WIDTH-1:0] ent0;
    logic [DATA_WIDTH-1:0] ent1;
    obuf_cnt_t             cnt;

    // ent0 is always the head; ent1 only ever holds the second-oldest word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= '0;
        end else begin
            unique case ({load, pop})
                2'b10: begin
                    if (cnt == 2'd0) ent0 <= load_data;
                    else             ent1 <= load_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Pop implies cnt >= 1; count is unchanged.
                    if (cnt == 2'd1) begin
                        ent0 <= load_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = ent0;
    assign count = cnt;

endmodule

// File: rtl/dpr_fifo_ctrl.sv
// Purpose: FIFO controller around an external dual-port RAM (port A write, port B read).
// Latency: push to out_valid is 2 edges when empty; one push and one pop per cycle sustained.
// Backpressure: in_ready drops when the RAM holds 2**ADDR_WIDTH words; out_ready stalls the buffer.
// Ports: clk, rst_n, io (push/pop handshake), a_* (RAM write), b_* (RAM read), level.
module dpr_fifo_ctrl #(
    parameter int DATA_WIDTH = dpr_fifo_ctrl_pkg::DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = dpr_fifo_ctrl_pkg::ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dpr_fifo_ctrl_if.slave        io,
    output logic [DATA_WIDTH-1:0] a_data,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic                  a_we,
    output logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_we,
    input  logic [DATA_WIDTH-1:0] b_q,
    output logic [ADDR_WIDTH+1:0] level
);
    import dpr_fifo_ctrl_pkg::*;

    localparam logic [ADDR_WIDTH:0] RAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    // One extra pointer bit distinguishes full from empty.
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] ram_count;
    logic                inflight;
    obuf_cnt_t           obuf_count;
    logic                push;
    logic                pop;
    logic                rd_issue;
    logic [2:0]          obuf_need;

    assign ram_count = wr_ptr - rd_ptr;

    // Depends only on registered pointers (and reset), never on out_ready or in_valid,
    // so a read issuing while full does not open a slot until the next cycle.
    assign io.in_ready  = rst_n && (ram_count < RAM_DEPTH);
    assign push         = io.in_valid && io.in_ready;

    assign io.out_valid = (obuf_count != 2'd0);
    assign pop          = io.out_valid && io.out_ready;

    // Slots the buffer will still need after this edge; a read is only launched
    // if its word is guaranteed a free slot when it returns next cycle.
    // pop implies obuf_count >= 1, so this never underflows.
    assign obuf_need = {1'b0, obuf_count} + {2'b00, inflight} - {2'b00, pop};
    // ram_count > 0 means rd_ptr addresses a word written on an earlier edge,
    // so the read never collides with this cycle's write.
    assign rd_issue  = (ram_count != '0) && (obuf_need <= 3'd1);

    assign a_we   = push;
    assign a_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign a_data = io.in_data;
    assign b_addr = rd_ptr[ADDR_WIDTH-1:0];
    assign b_we   = 1'b0;
    assign b_data = '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            level    <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
            // b_q carries the issued word exactly one cycle later.
            inflight <= rd_issue;
            if (push && !pop)      level <= level + 1'b1;
            else if (!push && pop) level <= level - 1'b1;
        end
    end

    dpr_fifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (inflight),
        .load_data (b_q),
        .pop       (pop),
        .head      (io.out_data),
        .count     (obuf_count)
    );

endmodule
